// File: rtl/wb_blkcopy_pkg.sv
// Shared types and constants for the Wishbone block-copy engine.
package wb_blkcopy_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_WR   = 3'd2,
    ST_GAP  = 3'd3,
    ST_FIN  = 3'd4
  } state_e;

  localparam logic [31:0] WORD_STRIDE = 32'd4;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & ~32'h3;
  endfunction

endpackage

// File: rtl/wb_blkcopy_if.sv
// Wishbone classic bus bundle between the copy engine (master) and the memory slave.
interface wb_blkcopy_if;

  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic        wb_stb_o;
  logic        wb_cyc_o;
  logic        wb_we_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;
  logic        wb_err_i;

  modport master (
    output wb_adr_o, wb_dat_o, wb_sel_o, wb_stb_o, wb_cyc_o, wb_we_o,
    input  wb_dat_i, wb_ack_i, wb_err_i
  );

  modport slave (
    input  wb_adr_o, wb_dat_o, wb_sel_o, wb_stb_o, wb_cyc_o, wb_we_o,
    output wb_dat_i, wb_ack_i, wb_err_i
  );

endinterface

// File: rtl/wb_blkcopy.sv
// Word-by-word memory-to-memory copy over a Wishbone master port.
// Optional bus-cycle watchdog enabled by defining CFG_WBCOPY_TIMEOUT_EN.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for start; only state in which start is accepted
// ST_RD    | read cycle on source word, waiting for ack/err
// ST_WR    | write cycle of captured word to destination, waiting ack/err
// ST_GAP   | one idle bus cycle between words so other masters can win
// ST_FIN   | one-cycle done pulse, then back to idle
module wb_blkcopy
  import wb_blkcopy_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  input  logic          start,
  input  logic [31:0]   src_adr,
  input  logic [31:0]   dst_adr,
  input  logic [15:0]   len,
  output logic          busy,
  output logic          done,
  output logic          error,
  wb_blkcopy_if.master  wb
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("wb_blkcopy: TIMEOUT_CYCLES must be within 1..255");
  end

  state_e      state_q, state_d;
  logic [31:0] src_q, src_d;
  logic [31:0] dst_q, dst_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic [15:0] rem_q, rem_d;
  logic        err_q, err_d;
  logic        bus_act;
  logic        tmo_hit;

  assign bus_act = (state_q == ST_RD) || (state_q == ST_WR);

`ifdef CFG_WBCOPY_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] tmo_q, tmo_d;

  // Counter is zero in every non-bus state, so each new RD/WR starts fresh.
  assign tmo_hit = bus_act && !wb.wb_ack_i && !wb.wb_err_i && (tmo_q == TMO_LAST);

  always_comb begin
    tmo_d = 8'd0;
    if (bus_act && !wb.wb_ack_i && !wb.wb_err_i) begin
      tmo_d = tmo_q + 8'd1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      tmo_q <= 8'd0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    rem_d   = rem_q;
    err_d   = err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          err_d = 1'b0;
          rem_d = len;
          adr_d = word_align(src_adr);
          src_d = word_align(src_adr) + WORD_STRIDE;
          dst_d = word_align(dst_adr);
          state_d = (len == 16'd0) ? ST_FIN : ST_RD;
        end
      end

      ST_RD: begin
        if (wb.wb_err_i || tmo_hit) begin
          err_d   = 1'b1;
          state_d = ST_FIN;
        end else if (wb.wb_ack_i) begin
          dat_d   = wb.wb_dat_i;
          adr_d   = dst_q;
          dst_d   = dst_q + WORD_STRIDE;
          state_d = ST_WR;
        end
      end

      ST_WR: begin
        if (wb.wb_err_i || tmo_hit) begin
          err_d   = 1'b1;
          state_d = ST_FIN;
        end else if (wb.wb_ack_i) begin
          rem_d = rem_q - 16'd1;
          if (rem_q == 16'd1) begin
            state_d = ST_FIN;
          end else begin
            adr_d   = src_q;
            src_d   = src_q + WORD_STRIDE;
            state_d = ST_GAP;
          end
        end
      end

      ST_GAP: state_d = ST_RD;

      ST_FIN: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= ST_IDLE;
      src_q   <= 32'd0;
      dst_q   <= 32'd0;
      adr_q   <= 32'd0;
      dat_q   <= 32'd0;
      rem_q   <= 16'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      rem_q   <= rem_d;
      err_q   <= err_d;
    end
  end

  assign wb.wb_cyc_o = bus_act;
  assign wb.wb_stb_o = bus_act;
  assign wb.wb_we_o  = (state_q == ST_WR);
  assign wb.wb_sel_o = bus_act ? 4'hF : 4'h0;
  assign wb.wb_adr_o = adr_q;
  assign wb.wb_dat_o = dat_q;

  assign busy  = (state_q != ST_IDLE);
  assign done  = (state_q == ST_FIN);
  assign error = err_q;

endmodule

// File: doc/wb_blkcopy.md
WB_BLKCOPY -- requirements
Module: wb_blkcopy

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning bus-cycle watchdog limit in clocks (8-bit range, 1..255).
REQ-002 SHALL have port sys_clk  input  1  sole clock; all logic rising-edge.
REQ-003 SHALL have port sys_rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port start  input  1  one-cycle request to begin copy.
REQ-005 SHALL have port src_adr  input  32  source byte address, sampled on accepted start.
REQ-006 SHALL have port dst_adr  input  32  destination byte address, sampled on accepted start.
REQ-007 SHALL have port len  input  16  copy length in 32-bit words, sampled on accepted start.
REQ-008 SHALL have port busy  output  1  high from accepted start through the done pulse.
REQ-009 SHALL have port done  output  1  one-cycle completion pulse.
REQ-010 SHALL have port error  output  1  sticky abort flag, cleared on next accepted start.
REQ-011 SHALL have Wishbone master ports wb_adr_o 32, wb_dat_o 32, wb_sel_o 4, wb_stb_o 1, wb_cyc_o 1, wb_we_o 1 (outputs) and wb_dat_i 32, wb_ack_i 1, wb_err_i 1 (inputs).

Function
REQ-012 SHALL implement FSM states IDLE, RD, WR, GAP, FIN.
REQ-013 IDLE: start accepted only in IDLE; start in any other state ignored.
REQ-014 Accepted start with len!=0 -> RD; cyc/stb asserted the following cycle (start in cycle N, stb in N+1).
REQ-015 Accepted start with len==0 -> FIN directly; no bus activity.
REQ-016 Addresses SHALL be word-aligned: wb_adr_o[1:0] forced 0; word i at src_adr+4*i / dst_adr+4*i, 32-bit wrap-around silently.
REQ-017 RD: cyc=stb=1, we=0, sel=4'hF; on wb_ack_i capture wb_dat_i into data register -> WR.
REQ-018 WR: cyc=stb=1, we=1, sel=4'hF, wb_dat_o=captured word, stb asserted the cycle after read ack (cyc held high RD->WR).
REQ-019 WR ack: decrement remaining count; remaining==0 -> FIN, else -> GAP.
REQ-020 GAP: cyc=stb=0 exactly one cycle (arbitration opportunity), then RD.
REQ-021 FIN: done=1 one cycle, cyc=stb=0, then IDLE; busy falls with FIN exit.
REQ-022 wb_err_i in RD or WR (ack ignored if simultaneous) -> error=1, FIN; remaining words abandoned.
REQ-023 Outside RD/WR, wb_cyc_o, wb_stb_o, wb_we_o SHALL be 0; wb_dat_o holds last value.
REQ-024 Remaining-count SHALL be 16 bits; len=16'hFFFF copies 65535 words.

Reset
REQ-025 sys_rst SHALL force IDLE, busy=0, done=0, error=0, cyc=stb=we=0, sel=0, adr=0, dat_o=0, counters=0.
REQ-026 sys_rst mid-transfer SHALL drop cyc/stb the next cycle with no done pulse.

Configuration
REQ-027 Macro CFG_WBCOPY_TIMEOUT_EN defined: 8-bit counter cleared on entering RD/WR, increments each cycle without ack/err; reaching TIMEOUT_CYCLES -> error=1, FIN.
REQ-028 Macro CFG_WBCOPY_TIMEOUT_EN undefined: no counter; RD/WR wait indefinitely for ack/err.

Structure
REQ-029 State encodings and the word-stride constant (4) SHALL live in shared package wb_blkcopy_pkg.
REQ-030 No sub-module; single flat FSM plus datapath; Wishbone slave under test is existing block RAM controller.

Verification
REQ-031 len=4, src=0x100, dst=0x800, RAM preloaded 0x11..0x44 -> reads 0x100..0x10C, writes 0x800..0x80C same data, one done pulse, error=0.
REQ-032 len=0 -> done in cycle N+1, wb_cyc_o never asserted, error=0.
REQ-033 wb_err_i on 2nd read of len=3 -> error=1, done pulse, exactly 1 write issued.
REQ-034 timeout build, TIMEOUT_CYCLES=16, slave never acks -> stb held 16 cycles, then error=1, done.
REQ-035 sys_rst asserted during WR of word 2 -> next cycle cyc=0, busy=0, no done; fresh start then copies normally.
REQ-036 start pulsed while busy -> ignored, original transfer completes unchanged, one done pulse.
